uart_alu_ctrl: RTL and testbench

//  Framed command controller between the RX FIFO, an N-bit ALU and the UART TX path.
//  - Parses a frame [START][OP][A bytes][B bytes] with multi-byte operands, LSB first.
//  - Issues one ALU operation, waits a configurable latency, then replies [RESULT bytes][STATUS].
//  - An inter-byte timeout aborts partial frames.
//  - Successor of the single-byte interface FSM; sits in the UART-ALU top level.

---
 rtl/uart_alu_pkg.sv | 35 +++
 rtl/frame_timeout_timer.sv | 30 +++
 rtl/uart_alu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_alu_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the framed UART/ALU command controller.
// Holds the FSM state encoding, the frame start marker, status bit positions and opcodes.
package uart_alu_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GET_OP    = 3'd1,
      GET_A     = 3'd2,
      GET_B     = 3'd3,
      EXEC      = 3'd4,
      WAIT      = 3'd5,
      SEND_RES  = 3'd6,
      SEND_STAT = 3'd7
   } state_t;

   localparam logic [7:0] START_BYTE_DEFAULT = 8'hFF;

   localparam int STAT_ZERO    = 0;
   localparam int STAT_CARRY   = 1;
   localparam int STAT_TIMEOUT = 2;

   localparam logic [5:0] ADD = 6'h20;
   localparam logic [5:0] SUB = 6'h22;

   function automatic logic [7:0] status_byte(input logic timeout, input logic carry,
                                              input logic zero);
      logic [7:0] s;
      s               = 8'h00;
      s[STAT_TIMEOUT] = timeout;
      s[STAT_CARRY]   = carry;
      s[STAT_ZERO]    = zero;
      return s;
   endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// Counts consecutive idle cycles inside a frame; expired flags the cycle on which
// the count has reached TIMEOUT_CYCLES-1 while still idle.
module frame_timeout_timer #(
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable && (count_reg != LAST_CNT)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   assign expired = enable && !clear && (count_reg == LAST_CNT);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Framed command controller: parses [START][OP][A][B] from the RX FIFO, runs one ALU
// operation and replies [RESULT bytes][STATUS]; partial frames are aborted on timeout.
module uart_alu_ctrl
   import uart_alu_pkg::*;
#(
   parameter int                 NB_BYTE        = 8,
   parameter int                 NB_OPERAND     = 16,
   parameter int                 NB_OP          = 6,
   parameter logic [NB_BYTE-1:0] START_BYTE     = START_BYTE_DEFAULT,
   parameter int                 ALU_LATENCY    = 1,
   parameter int                 TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NB_BYTE-1:0]    data_rx,
   input  logic                  empty_rx,
   output logic                  rd,
   input  logic                  tx_full,
   output logic                  wr_tx,
   output logic [NB_BYTE-1:0]    data_tx,
   output logic                  alu_start,
   output logic [NB_OP-1:0]      alu_op,
   output logic [NB_OPERAND-1:0] alu_a,
   output logic [NB_OPERAND-1:0] alu_b,
   input  logic [NB_OPERAND-1:0] alu_result,
   input  logic                  alu_carry,
   input  logic                  alu_zero,
   output logic                  busy,
   output logic                  err_timeout
);

   localparam int NBYTES = NB_OPERAND / NB_BYTE;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int LAT_W  = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
   localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(ALU_LATENCY - 1);

   state_t                  state;
   logic [IDX_W-1:0]        idx_reg;
   logic [LAT_W-1:0]        lat_reg;
   logic [NB_OP-1:0]        op_reg;
   logic [NB_OPERAND-1:0]   a_reg;
   logic [NB_OPERAND-1:0]   b_reg;
   logic [NB_OPERAND-1:0]   res_reg;
   logic [NB_BYTE-1:0]      status_reg;
   logic [NB_BYTE-1:0]      tx_hold_reg;
   logic                    err_reg;

   logic                    rx_phase;
   logic                    tx_phase;
   logic                    rd_en;
   logic                    wr_en;
   logic                    expired;
   logic                    timeout_abort;
   logic [NB_BYTE-1:0]      tx_byte;

   assign rx_phase = (state == GET_OP) || (state == GET_A) || (state == GET_B);
   assign tx_phase = (state == SEND_RES) || (state == SEND_STAT);

   // Handshakes are combinational so a byte is sampled in the cycle it is popped/written.
   assign rd_en = !reset && !empty_rx && ((state == IDLE) || rx_phase);
   assign wr_en = !reset && !tx_full && tx_phase;
   assign timeout_abort = rx_phase && !rd_en && expired;

   always_comb begin
      tx_byte = status_reg;
      if (state == SEND_RES) begin
         tx_byte = res_reg[idx_reg*NB_BYTE +: NB_BYTE];
      end
   end

   frame_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (!rx_phase || !empty_rx),
      .enable (empty_rx),
      .expired(expired)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         idx_reg     <= '0;
         lat_reg     <= '0;
         op_reg      <= '0;
         a_reg       <= '0;
         b_reg       <= '0;
         res_reg     <= '0;
         status_reg  <= '0;
         tx_hold_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         if (wr_en) begin
            tx_hold_reg <= tx_byte;
         end
         if (timeout_abort) begin
            status_reg <= NB_BYTE'(status_byte(1'b1, 1'b0, 1'b0));
            err_reg    <= 1'b1;
            idx_reg    <= '0;
            state      <= SEND_STAT;
         end else begin
            case (state)
               IDLE: begin
                  if (rd_en && (data_rx == START_BYTE)) begin
                     idx_reg <= '0;
                     state   <= GET_OP;
                  end
               end
               GET_OP: begin
                  if (rd_en) begin
                     op_reg  <= data_rx[NB_OP-1:0];
                     idx_reg <= '0;
                     state   <= GET_A;
                  end
               end
               GET_A: begin
                  if (rd_en) begin
                     a_reg[idx_reg*NB_BYTE +: NB_BYTE] <= data_rx;
                     if (idx_reg == LAST_IDX) begin
                        idx_reg <= '0;
                        state   <= GET_B;
                     end else begin
                        idx_reg <= idx_reg + 1'b1;
                     end
                  end
               end
               GET_B: begin
                  if (rd_en) begin
                     b_reg[idx_reg*NB_BYTE +: NB_BYTE] <= data_rx;
                     if (idx_reg == LAST_IDX) begin
                        idx_reg <= '0;
                        state   <= EXEC;
                     end else begin
                        idx_reg <= idx_reg + 1'b1;
                     end
                  end
               end
               EXEC: begin
                  lat_reg <= '0;
                  state   <= WAIT;
               end
               WAIT: begin
                  if (lat_reg == LAST_LAT) begin
                     res_reg    <= alu_result;
                     status_reg <= NB_BYTE'(status_byte(1'b0, alu_carry, alu_zero));
                     idx_reg    <= '0;
                     state      <= SEND_RES;
                  end else begin
                     lat_reg <= lat_reg + 1'b1;
                  end
               end
               SEND_RES: begin
                  if (!tx_full) begin
                     if (idx_reg == LAST_IDX) begin
                        idx_reg <= '0;
                        state   <= SEND_STAT;
                     end else begin
                        idx_reg <= idx_reg + 1'b1;
                     end
                  end
               end
               SEND_STAT: begin
                  if (!tx_full) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign rd          = rd_en;
   assign wr_tx       = wr_en;
   assign data_tx     = wr_en ? tx_byte : tx_hold_reg;
   assign alu_start   = (state == EXEC);
   assign alu_op      = op_reg;
   assign alu_a       = a_reg;
   assign alu_b       = b_reg;
   assign busy        = (state != IDLE);
   assign err_timeout = err_reg;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Self-checking bench for uart_alu_ctrl: FIFO/TX/ALU environment models plus
// directed and randomized frames compared against a byte-level reply model.
module tb_uart_alu_ctrl;
   import uart_alu_pkg::*;

   localparam int NB_OPERAND     = 16;
   localparam int ALU_LATENCY    = 1;
   localparam int TIMEOUT_CYCLES = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  data_rx;
   logic        empty_rx;
   logic        rd;
   logic        tx_full = 1'b0;
   logic        wr_tx;
   logic [7:0]  data_tx;
   logic        alu_start;
   logic [5:0]  alu_op;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [15:0] alu_result;
   logic        alu_carry;
   logic        alu_zero;
   logic        busy;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_alu_ctrl #(
      .NB_BYTE(8), .NB_OPERAND(NB_OPERAND), .NB_OP(6), .START_BYTE(8'hFF),
      .ALU_LATENCY(ALU_LATENCY), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .reset(reset), .data_rx(data_rx), .empty_rx(empty_rx), .rd(rd),
      .tx_full(tx_full), .wr_tx(wr_tx), .data_tx(data_tx), .alu_start(alu_start),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .alu_carry(alu_carry), .alu_zero(alu_zero), .busy(busy), .err_timeout(err_timeout)
   );

   // ---------------- RX FIFO model (first-word-fall-through) ----------------
   logic [7:0] fifo_mem [0:255];
   int rd_ptr = 0;
   int wr_ptr = 0;
   int rd_empty_viol = 0;
   assign data_rx  = fifo_mem[rd_ptr[7:0]];
   assign empty_rx = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (rd && empty_rx) rd_empty_viol <= rd_empty_viol + 1;
      if (rd && !empty_rx) rd_ptr <= rd_ptr + 1;
   end

   task automatic push(input logic [7:0] b);
      fifo_mem[wr_ptr[7:0]] = b;
      wr_ptr = wr_ptr + 1;
   endtask

   // ---------------- TX path model ----------------
   logic [7:0] tx_log[$];
   int tx_full_viol = 0;
   bit rand_full = 1'b0;
   logic force_full = 1'b0;

   always @(posedge clk) begin
      if (wr_tx) begin
         tx_log.push_back(data_tx);
         if (tx_full) tx_full_viol <= tx_full_viol + 1;
      end
   end

   always @(negedge clk) tx_full <= rand_full ? ($urandom_range(0, 2) == 0) : force_full;

   // ---------------- ALU model ----------------
   function automatic void alu_fn(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic c, output logic z);
      logic [16:0] wide;
      case (op)
         ADD:     wide = {1'b0, a} + {1'b0, b};
         SUB:     wide = {1'b0, a} - {1'b0, b};
         default: wide = {1'b0, a ^ b};
      endcase
      r = wide[15:0];
      c = wide[16];
      z = (wide == 17'd0);
   endfunction

   logic [15:0] start_a[$];
   logic [15:0] start_b[$];
   logic [5:0]  start_op[$];
   int start_cnt = 0;
   int start_width_viol = 0;
   int err_cnt = 0;
   logic prev_start = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         alu_result <= '0;
         alu_carry  <= 1'b0;
         alu_zero   <= 1'b0;
         prev_start <= 1'b0;
      end else begin
         prev_start <= alu_start;
         if (alu_start) begin
            logic [15:0] r;
            logic c, z;
            alu_fn(alu_op, alu_a, alu_b, r, c, z);
            alu_result <= r;
            alu_carry  <= c;
            alu_zero   <= z;
            start_a.push_back(alu_a);
            start_b.push_back(alu_b);
            start_op.push_back(alu_op);
            start_cnt <= start_cnt + 1;
            if (prev_start) start_width_viol <= start_width_viol + 1;
         end
         if (err_timeout) err_cnt <= err_cnt + 1;
      end
   end

   // Reply model: result bytes LSB first, then {5'b0, timeout, carry, zero}.
   function automatic logic [23:0] ref_reply(input logic [5:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      logic [15:0] r;
      logic c, z;
      alu_fn(op, a, b, r, c, z);
      return {5'b0, 1'b0, c, z, r[15:8], r[7:0]};
   endfunction

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic push_frame(input logic [7:0] opb, input logic [15:0] a, input logic [15:0] b,
                             input int gap_max);
      logic [7:0] bytes [6];
      bytes = '{8'hFF, opb, a[7:0], a[15:8], b[7:0], b[15:8]};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         push(bytes[i]);
         if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
      end
   endtask

   task automatic wait_reply(input int target, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (tx_log.size() >= target && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++;
      if ({rd, wr_tx, data_tx, alu_start, alu_op, alu_a, alu_b, busy, err_timeout} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rd=%b wr=%b dtx=%h st=%b op=%h a=%h b=%h busy=%b err=%b, want all 0",
                  rd, wr_tx, data_tx, alu_start, alu_op, alu_a, alu_b, busy, err_timeout);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b want 0", busy);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_add;
      int base = tx_log.size();
      int s0 = start_cnt;
      bit ok;
      logic [7:0] exp [3];
      exp = '{8'h35, 8'h12, 8'h00};
      push_frame(8'h20, 16'h1234, 16'h0001, 0);
      wait_reply(base + 3, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL add_reply_wait: got %0d bytes, want 3", tx_log.size() - base);
         return;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_log[base+i] !== exp[i]) begin
            errors++;
            $display("FAIL add_tx%0d: got %h want %h", i, tx_log[base+i], exp[i]);
         end
      end
      checks++;
      if (start_cnt - s0 != 1 || start_a[$] !== 16'h1234 || start_b[$] !== 16'h0001 || start_op[$] !== 6'h20) begin
         errors++;
         $display("FAIL add_alu_issue: starts=%0d a=%h b=%h op=%h, want 1 1234 0001 20",
                  start_cnt - s0, start_a[$], start_b[$], start_op[$]);
      end
      $display("add: tx %h %h %h", tx_log[base], tx_log[base+1], tx_log[base+2]);
   endtask

   task automatic test_sub_zero;
      int base = tx_log.size();
      bit ok;
      logic [7:0] exp [3];
      exp = '{8'h00, 8'h00, 8'h01};
      push_frame(8'h22, 16'h0005, 16'h0005, 0);
      wait_reply(base + 3, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL sub_reply_wait: got %0d bytes, want 3", tx_log.size() - base);
         return;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_log[base+i] !== exp[i]) begin
            errors++;
            $display("FAIL sub_tx%0d: got %h want %h", i, tx_log[base+i], exp[i]);
         end
      end
      $display("sub_zero: tx %h %h %h", tx_log[base], tx_log[base+1], tx_log[base+2]);
   endtask

   task automatic test_garbage_carry;
      int base = tx_log.size();
      bit ok;
      logic [7:0] exp [3];
      exp = '{8'h00, 8'h00, 8'h02};
      @(negedge clk);
      push(8'h55);
      push(8'hAA);
      push_frame(8'h20, 16'hFFFF, 16'h0001, 0);
      wait_reply(base + 3, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL carry_reply_wait: got %0d bytes, want 3", tx_log.size() - base);
         return;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (tx_log[base+i] !== exp[i]) begin
            errors++;
            $display("FAIL carry_tx%0d: got %h want %h", i, tx_log[base+i], exp[i]);
         end
      end
      checks++;
      if (start_a[$] !== 16'hFFFF || rd_ptr != wr_ptr) begin
         errors++;
         $display("FAIL carry_operand: a=%h fifo_left=%0d, want FFFF 0", start_a[$], wr_ptr - rd_ptr);
      end
      $display("garbage_carry: tx %h %h %h", tx_log[base], tx_log[base+1], tx_log[base+2]);
   endtask

   task automatic test_timeout;
      int base = tx_log.size();
      int e0 = err_cnt;
      int s0 = start_cnt;
      bit ok;
      @(negedge clk);
      push(8'hFF);
      push(8'h20);
      repeat (60) @(negedge clk);
      checks++;
      if (err_cnt != e0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL timeout_early: err_pulses=%0d busy=%b, want 0 1", err_cnt - e0, busy);
      end
      wait_reply(base + 1, 100, ok);
      repeat (5) @(negedge clk);
      checks++;
      if (!ok || tx_log.size() != base + 1 || err_cnt - e0 != 1 || start_cnt != s0) begin
         errors++;
         $display("FAIL timeout_abort: ok=%b bytes=%0d pulses=%0d starts=%0d, want 1 1 1 0",
                  ok, tx_log.size() - base, err_cnt - e0, start_cnt - s0);
      end else begin
         checks++;
         if (tx_log[base] !== 8'h04 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_status: got %h busy=%b, want 04 0", tx_log[base], busy);
         end
      end
      $display("timeout: %0d bytes, %0d pulses", tx_log.size() - base, err_cnt - e0);
      test_add();
   endtask

   task automatic test_tx_stall;
      int base = tx_log.size();
      bit ok;
      logic [7:0] exp [3];
      exp = '{8'h35, 8'h12, 8'h00};
      force_full = 1'b1;
      repeat (2) @(negedge clk);
      push_frame(8'h20, 16'h1234, 16'h0001, 0);
      repeat (50) @(negedge clk);
      checks++;
      if (tx_log.size() != base || busy !== 1'b1) begin
         errors++;
         $display("FAIL stall_hold: bytes=%0d busy=%b, want 0 1", tx_log.size() - base, busy);
      end
      force_full = 1'b0;
      wait_reply(base + 3, 200, ok);
      repeat (10) @(negedge clk);
      checks++;
      if (!ok || tx_log.size() != base + 3) begin
         errors++;
         $display("FAIL stall_count: got %0d bytes, want 3", tx_log.size() - base);
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx_log[base+i] !== exp[i]) begin
               errors++;
               $display("FAIL stall_tx%0d: got %h want %h", i, tx_log[base+i], exp[i]);
            end
         end
      end
      $display("tx_stall: %0d bytes after release", tx_log.size() - base);
   endtask

   task automatic test_reset_mid;
      int base = tx_log.size();
      @(negedge clk);
      push(8'hFF);
      push(8'h20);
      push(8'h34);
      repeat (4) @(negedge clk);
      checks++;
      if (busy !== 1'b1 || alu_a[7:0] !== 8'h34) begin
         errors++;
         $display("FAIL midreset_pre: busy=%b a=%h, want 1 xx34", busy, alu_a);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({rd, wr_tx, data_tx, alu_start, alu_op, alu_a, alu_b, busy, err_timeout} !== '0) begin
         errors++;
         $display("FAIL midreset_async: rd=%b wr=%b dtx=%h st=%b op=%h a=%h b=%h busy=%b err=%b, want all 0",
                  rd, wr_tx, data_tx, alu_start, alu_op, alu_a, alu_b, busy, err_timeout);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (tx_log.size() != base || busy !== 1'b0) begin
         errors++;
         $display("FAIL midreset_quiet: bytes=%0d busy=%b, want 0 0", tx_log.size() - base, busy);
      end
      $display("reset_mid: partial frame dropped");
      test_add();
   endtask

   task automatic test_random;
      rand_full = 1'b1;
      for (int n = 0; n < 20; n++) begin
         int base = tx_log.size();
         int s0 = start_cnt;
         bit ok;
         logic [5:0] op;
         logic [7:0] opb;
         logic [15:0] a, b;
         logic [23:0] exp;
         case ($urandom_range(0, 2))
            0:       op = ADD;
            1:       op = SUB;
            default: op = 6'($urandom);
         endcase
         opb = {2'($urandom), op};
         a = 16'($urandom);
         b = 16'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            push(8'($urandom_range(0, 254)));
         end
         push_frame(opb, a, b, 3);
         wait_reply(base + 3, 500, ok);
         exp = ref_reply(op, a, b);
         checks++;
         if (!ok || tx_log.size() != base + 3) begin
            errors++;
            $display("FAIL rand%0d_count: got %0d bytes, want 3", n, tx_log.size() - base);
            continue;
         end
         checks++;
         if ({tx_log[base+2], tx_log[base+1], tx_log[base]} !== exp) begin
            errors++;
            $display("FAIL rand%0d_tx: got %h %h %h want %h %h %h", n, tx_log[base],
                     tx_log[base+1], tx_log[base+2], exp[7:0], exp[15:8], exp[23:16]);
         end
         checks++;
         if (start_cnt - s0 != 1 || start_op[$] !== op || start_a[$] !== a || start_b[$] !== b) begin
            errors++;
            $display("FAIL rand%0d_issue: starts=%0d op=%h a=%h b=%h want 1 %h %h %h",
                     n, start_cnt - s0, start_op[$], start_a[$], start_b[$], op, a, b);
         end
         $display("frame %0d: op=%h a=%h b=%h tx=%h %h %h", n, op, a, b,
                  tx_log[base], tx_log[base+1], tx_log[base+2]);
      end
      rand_full = 1'b0;
      force_full = 1'b0;
   endtask

   task automatic test_protocol;
      checks++;
      if (rd_empty_viol != 0 || tx_full_viol != 0 || start_width_viol != 0) begin
         errors++;
         $display("FAIL protocol: rd_on_empty=%0d wr_on_full=%0d long_start=%0d, want 0 0 0",
                  rd_empty_viol, tx_full_viol, start_width_viol);
      end
      $display("protocol: handshake rules checked");
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub_zero();
      test_garbage_carry();
      test_timeout();
      test_tx_stall();
      test_reset_mid();
      test_random();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
